// File: rtl/pc_seq.sv
// Next-PC sequencer for the MIPS program counter: boot vector, sequential
// advance, branch/jump/eret redirects (held across stalls) and a two-cycle
// exception entry that writes EPC/Cause before loading the handler vector.
module pc_seq #(
   parameter int unsigned  N         = 32,
   parameter logic [N-1:0] RESET_VEC = 32'h00400000,
   parameter logic [N-1:0] EXC_VEC   = 32'h00400004,
   parameter logic [4:0]   ADE_CODE  = 5'd4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] pc_cur,
   input  logic         stall,
   input  logic         br_take,
   input  logic [N-1:0] br_target,
   input  logic         jmp_take,
   input  logic [N-1:0] jmp_target,
   input  logic         eret,
   input  logic [N-1:0] epc_in,
   input  logic         exc_req,
   input  logic [4:0]   exc_code,
   output logic         pc_ena,
   output logic [N-1:0] pc_next,
   output logic         epc_we,
   output logic [N-1:0] epc_out,
   output logic         cause_we,
   output logic [4:0]   cause_code,
   output logic         busy
);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_EXC_SAVE, S_EXC_VEC} state_t;

   state_t       state;
   logic         pending_vld;
   logic [N-1:0] pending_tgt;
   logic [N-1:0] exc_pc_q;
   logic [4:0]   exc_code_q;

   logic         redir_new;
   logic         redir_any;
   logic         misalign;
   logic         exc_take;
   logic [N-1:0] new_tgt;
   logic [N-1:0] sel_tgt;
   logic [N-1:0] seq_pc;
   logic [4:0]   take_code;

   // Redirect target selection and exception qualification while running
   always_comb begin
      redir_new = eret | jmp_take | br_take;
      if (eret)          new_tgt = epc_in;
      else if (jmp_take) new_tgt = jmp_target;
      else               new_tgt = br_target;
      // a held redirect always beats anything arriving this cycle
      sel_tgt   = pending_vld ? pending_tgt : new_tgt;
      redir_any = pending_vld | redir_new;
      misalign  = redir_any & (sel_tgt[1:0] != 2'b00);
      exc_take  = (state == S_RUN) & (exc_req | misalign);
      take_code = exc_req ? exc_code : ADE_CODE;
      seq_pc    = pc_cur + N'(4);
   end

   // PC and CP0 outputs; RUN is Mealy so the PC moves on the same edge
   always_comb begin
      pc_ena     = 1'b0;
      pc_next    = RESET_VEC;
      epc_we     = 1'b0;
      epc_out    = '0;
      cause_we   = 1'b0;
      cause_code = '0;
      busy       = 1'b0;
      if (rst_n) begin
         unique case (state)
            S_BOOT: begin
               pc_ena  = 1'b1;
               pc_next = RESET_VEC;
            end
            S_RUN: begin
               pc_next = redir_any ? sel_tgt : seq_pc;
               pc_ena  = ~stall & ~exc_take;
            end
            S_EXC_SAVE: begin
               epc_we     = 1'b1;
               epc_out    = exc_pc_q;
               cause_we   = 1'b1;
               cause_code = exc_code_q;
               busy       = 1'b1;
            end
            S_EXC_VEC: begin
               // loads regardless of stall: exception entry flushes the pipe
               pc_ena  = 1'b1;
               pc_next = EXC_VEC;
               busy    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Sequencer state, pending redirect and captured exception context
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_BOOT;
         pending_vld <= 1'b0;
         pending_tgt <= '0;
         exc_pc_q    <= '0;
         exc_code_q  <= '0;
      end else begin
         unique case (state)
            S_BOOT: state <= S_RUN;
            S_RUN: begin
               if (exc_take) begin
                  state       <= S_EXC_SAVE;
                  exc_pc_q    <= pc_cur;
                  exc_code_q  <= take_code;
                  pending_vld <= 1'b0;
               end else if (!stall) begin
                  pending_vld <= 1'b0;
               end else if (redir_new && !pending_vld) begin
                  pending_vld <= 1'b1;
                  pending_tgt <= new_tgt;
               end
            end
            S_EXC_SAVE: state <= S_EXC_VEC;
            S_EXC_VEC:  state <= S_RUN;
            default:    state <= S_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: per-cycle expected outputs are queued when
// the stimulus is applied and popped/compared at the following falling edge.
module tb_pc_seq;

   localparam logic [31:0] RV = 32'h00400000;
   localparam logic [31:0] EV = 32'h00400004;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_cur, br_target, jmp_target, epc_in;
   logic        stall, br_take, jmp_take, eret, exc_req;
   logic [4:0]  exc_code;
   logic        pc_ena, epc_we, cause_we, busy;
   logic [31:0] pc_next, epc_out;
   logic [4:0]  cause_code;

   int checks   = 0;
   int failures = 0;

   pc_seq #(.N(32), .RESET_VEC(RV), .EXC_VEC(EV), .ADE_CODE(5'd4)) dut (
      .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .stall(stall),
      .br_take(br_take), .br_target(br_target), .jmp_take(jmp_take),
      .jmp_target(jmp_target), .eret(eret), .epc_in(epc_in),
      .exc_req(exc_req), .exc_code(exc_code), .pc_ena(pc_ena),
      .pc_next(pc_next), .epc_we(epc_we), .epc_out(epc_out),
      .cause_we(cause_we), .cause_code(cause_code), .busy(busy)
   );

   always #5 clk = ~clk;

   // {pc_ena, pc_next, epc_we, epc_out, cause_we, cause_code, busy}
   logic [72:0] obs;
   assign obs = {pc_ena, pc_next, epc_we, epc_out, cause_we, cause_code, busy};

   typedef struct packed {
      logic [72:0] val;
      logic [72:0] mask;
   } exp_t;

   typedef struct packed {
      logic        rst;
      logic [31:0] pc;
      logic        stall;
      logic        br;
      logic [31:0] brt;
      logic        jmp;
      logic [31:0] jt;
      logic        eret;
      logic [31:0] epc;
      logic        exc;
      logic [4:0]  code;
   } stim_t;

   exp_t sb[$];

   // pc_next is only constrained when the PC loads, or during reset
   function automatic exp_t mk(logic ena, logic [31:0] nx, logic nx_care, logic ewe,
                               logic [31:0] eo, logic cwe, logic [4:0] cc, logic bz);
      exp_t e;
      e.val  = {ena, nx, ewe, eo, cwe, cc, bz};
      e.mask = {1'b1, {32{nx_care}}, 40'hFFFFFFFFFF};
      return e;
   endfunction

   function automatic stim_t st_mk(logic rst, logic [31:0] pc, logic stl, logic br, logic [31:0] brt,
                                   logic jmp, logic [31:0] jt, logic er, logic [31:0] epc,
                                   logic exc, logic [4:0] code);
      stim_t s;
      s.rst = rst; s.pc = pc; s.stall = stl; s.br = br; s.brt = brt; s.jmp = jmp;
      s.jt = jt; s.eret = er; s.epc = epc; s.exc = exc; s.code = code;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      rst_n = s.rst; pc_cur = s.pc; stall = s.stall; br_take = s.br; br_target = s.brt;
      jmp_take = s.jmp; jmp_target = s.jt; eret = s.eret; epc_in = s.epc;
      exc_req = s.exc; exc_code = s.code;
   endtask

   task automatic test_reset();
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(st_mk(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));        ex.push_back(mk(0, RV, 1, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0));        ex.push_back(mk(1, RV, 1, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h00400000, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(mk(1, 32'h00400004, 1, 0, 0, 0, 0, 0));
      foreach (st[i]) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            failures++; $display("FAIL reset[%0d] got=%h want=%h mask=%h", i, obs, e.val, e.mask);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_redirect_prio();
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(st_mk(1, 32'h00400010, 0, 1, 32'h00400040, 1, 32'h00400080, 0, 0, 0, 0));
      ex.push_back(mk(1, 32'h00400080, 1, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h00400080, 0, 1, 32'h00400040, 1, 32'h00400080, 1, 32'h00400300, 0, 0));
      ex.push_back(mk(1, 32'h00400300, 1, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h00400300, 0, 1, 32'h00400040, 0, 0, 0, 0, 0, 0));
      ex.push_back(mk(1, 32'h00400040, 1, 0, 0, 0, 0, 0));
      foreach (st[i]) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            failures++; $display("FAIL redirect_prio[%0d] got=%h want=%h", i, obs, e.val);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall_pending();
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(st_mk(1, 32'h00400040, 1, 1, 32'h00400100, 0, 0, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h00400040, 1, 0, 0, 1, 32'h00400200, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h00400040, 0, 0, 0, 0, 0, 0, 0, 0, 0));            ex.push_back(mk(1, 32'h00400100, 1, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h00400100, 0, 0, 0, 0, 0, 0, 0, 0, 0));            ex.push_back(mk(1, 32'h00400104, 1, 0, 0, 0, 0, 0));
      foreach (st[i]) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            failures++; $display("FAIL stall_pending[%0d] got=%h want=%h", i, obs, e.val);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_exception();
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(st_mk(1, 32'h00400020, 0, 0, 0, 0, 0, 1, 32'h00400500, 1, 5'd8));
      ex.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h00400020, 0, 1, 32'h00400700, 0, 0, 0, 0, 1, 5'd9));
      ex.push_back(mk(0, 0, 0, 1, 32'h00400020, 1, 5'd8, 1));
      st.push_back(st_mk(1, 32'h00400020, 1, 1, 32'h00400100, 0, 0, 0, 0, 0, 0));
      ex.push_back(mk(1, EV, 1, 0, 0, 0, 0, 1));
      st.push_back(st_mk(1, EV, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      ex.push_back(mk(1, 32'h00400008, 1, 0, 0, 0, 0, 0));
      foreach (st[i]) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            failures++; $display("FAIL exception[%0d] got=%h want=%h", i, obs, e.val);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_misalign();
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(st_mk(1, 32'h00400030, 0, 0, 0, 1, 32'h00400102, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h00400030, 0, 0, 0, 0, 0, 0, 0, 0, 0));            ex.push_back(mk(0, 0, 0, 1, 32'h00400030, 1, 5'd4, 1));
      st.push_back(st_mk(1, 32'h00400030, 0, 0, 0, 0, 0, 0, 0, 0, 0));            ex.push_back(mk(1, EV, 1, 0, 0, 0, 0, 1));
      st.push_back(st_mk(1, EV, 0, 0, 0, 0, 0, 0, 0, 0, 0));                      ex.push_back(mk(1, 32'h00400008, 1, 0, 0, 0, 0, 0));
      foreach (st[i]) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            failures++; $display("FAIL misalign[%0d] got=%h want=%h", i, obs, e.val);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_exc_clears_pending();
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(st_mk(1, 32'h00400040, 1, 1, 32'h00400100, 0, 0, 0, 0, 0, 0)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h00400050, 1, 0, 0, 0, 0, 0, 0, 1, 5'd3));         ex.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h00400050, 1, 0, 0, 0, 0, 0, 0, 0, 0));            ex.push_back(mk(0, 0, 0, 1, 32'h00400050, 1, 5'd3, 1));
      st.push_back(st_mk(1, 32'h00400050, 1, 0, 0, 0, 0, 0, 0, 0, 0));            ex.push_back(mk(1, EV, 1, 0, 0, 0, 0, 1));
      st.push_back(st_mk(1, EV, 0, 0, 0, 0, 0, 0, 0, 0, 0));                      ex.push_back(mk(1, 32'h00400008, 1, 0, 0, 0, 0, 0));
      foreach (st[i]) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            failures++; $display("FAIL exc_clears_pending[%0d] got=%h want=%h", i, obs, e.val);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_wrap();
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(st_mk(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(mk(1, 32'h00000000, 1, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h00000000, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(mk(1, 32'h00000004, 1, 0, 0, 0, 0, 0));
      foreach (st[i]) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            failures++; $display("FAIL wrap[%0d] got=%h want=%h", i, obs, e.val);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_exc();
      stim_t st[$]; exp_t ex[$]; exp_t e;
      st.push_back(st_mk(1, 32'h00400060, 0, 0, 0, 0, 0, 0, 0, 1, 5'd12)); ex.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      st.push_back(st_mk(0, 32'h00400060, 0, 0, 0, 0, 0, 0, 0, 0, 0));     ex.push_back(mk(0, RV, 1, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, 32'h00400060, 1, 0, 0, 0, 0, 0, 0, 0, 0));     ex.push_back(mk(1, RV, 1, 0, 0, 0, 0, 0));
      st.push_back(st_mk(1, RV, 0, 0, 0, 0, 0, 0, 0, 0, 0));                ex.push_back(mk(1, 32'h00400004, 1, 0, 0, 0, 0, 0));
      foreach (st[i]) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            failures++; $display("FAIL reset_mid_exc[%0d] got=%h want=%h", i, obs, e.val);
         end
         @(posedge clk); #1;
      end
   endtask

   // Unstalled redirects every cycle, expected PC from a priority model
   task automatic test_back_to_back();
      stim_t s; exp_t e; logic [31:0] want;
      for (int i = 0; i < 16; i++) begin
         s = st_mk(1, $urandom() & 32'hFFFFFFFC, 0, 1'($urandom_range(0, 1)), $urandom() & 32'hFFFFFFFC,
                   1'($urandom_range(0, 1)), $urandom() & 32'hFFFFFFFC, 1'($urandom_range(0, 1)),
                   $urandom() & 32'hFFFFFFFC, 0, 0);
         if (s.eret)     want = s.epc;
         else if (s.jmp) want = s.jt;
         else if (s.br)  want = s.brt;
         else            want = s.pc + 32'd4;
         drive(s); sb.push_back(mk(1, want, 1, 0, 0, 0, 0, 0));
         @(negedge clk); e = sb.pop_front(); checks++;
         if ((obs & e.mask) !== (e.val & e.mask)) begin
            failures++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, obs, e.val);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      drive(st_mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      test_reset();
      test_redirect_prio();
      test_stall_pending();
      test_exception();
      test_misalign();
      test_exc_clears_pending();
      test_wrap();
      test_reset_mid_exc();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
